// File: rtl/alu_pipe_if.sv
// Request/response channel bundle for alu_pipe: issue side drives the request
// and response-ready, the pipe returns results, tag, error flag and op count.
interface alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             i_req_valid;
    logic             o_req_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [3:0]       i_op;
    logic [TAG_W-1:0] i_tag;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [WIDTH-1:0] o_res;
    logic [TAG_W-1:0] o_tag;
    logic             o_err;
    logic [31:0]      o_ops;

    modport master (
        output i_req_valid, i_a, i_b, i_op, i_tag, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_res, o_tag, o_err, o_ops
    );

    modport slave (
        input  i_req_valid, i_a, i_b, i_op, i_tag, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_res, o_tag, o_err, o_ops
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage handshaked ALU: S1 holds operands, S2 holds the tagged result.
// Optional response counter on o_ops is built when ALU_PIPE_STATS_EN is defined.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    alu_pipe_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SLL  = 4'h1;
    localparam logic [3:0] OP_SLT  = 4'h2;
    localparam logic [3:0] OP_SLTU = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'hD;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [3:0]       s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_res_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic             s2_err_q;

    logic [WIDTH-1:0] s2_res_d;
    logic             s2_err_d;
    logic [SH_W-1:0]  shamt;
    logic             s1_adv;
    logic             s2_adv;

    assign s2_adv = !s2_valid_q || bus.i_rsp_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign shamt  = s1_b_q[SH_W-1:0];

    always_comb begin
        s2_res_d = '0;
        s2_err_d = 1'b0;
        unique case (s1_op_q)
            OP_ADD:  s2_res_d = s1_a_q + s1_b_q;
            OP_SUB:  s2_res_d = s1_a_q - s1_b_q;
            OP_SLL:  s2_res_d = s1_a_q << shamt;
            OP_SRL:  s2_res_d = s1_a_q >> shamt;
            OP_SRA:  s2_res_d = $unsigned($signed(s1_a_q) >>> shamt);
            OP_SLT:  s2_res_d[0] = $signed(s1_a_q) < $signed(s1_b_q);
            OP_SLTU: s2_res_d[0] = s1_a_q < s1_b_q;
            OP_XOR:  s2_res_d = s1_a_q ^ s1_b_q;
            OP_OR:   s2_res_d = s1_a_q | s1_b_q;
            OP_AND:  s2_res_d = s1_a_q & s1_b_q;
            default: s2_err_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= bus.i_req_valid;
            if (bus.i_req_valid) begin
                s1_a_q   <= bus.i_a;
                s1_b_q   <= bus.i_b;
                s1_op_q  <= bus.i_op;
                s1_tag_q <= bus.i_tag;
            end
        end
    end

    // Result fields only move on an S2 load, so a stalled response stays stable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_tag_q   <= '0;
            s2_err_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_res_q <= s2_res_d;
                s2_tag_q <= s1_tag_q;
                s2_err_q <= s2_err_d;
            end
        end
    end

    assign bus.o_req_ready = i_rst_n && s1_adv;
    assign bus.o_rsp_valid = s2_valid_q;
    assign bus.o_res       = s2_res_q;
    assign bus.o_tag       = s2_tag_q;
    assign bus.o_err       = s2_err_q;

`ifdef ALU_PIPE_STATS_EN
    logic [31:0] ops_q;
    logic [31:0] ops_d;

    assign ops_d = ops_q + 32'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ops_q <= '0;
        end else if (s2_valid_q && bus.i_rsp_ready) begin
            ops_q <= ops_d;
        end
    end

    assign bus.o_ops = ops_q;
`else
    assign bus.o_ops = 32'h0;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: opcodes, corners, streaming, backpressure, reset.
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   rsp_count = 0;

    alu_pipe_if #(.WIDTH(32), .TAG_W(4)) bus ();

    alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_ops();
`ifdef ALU_PIPE_STATS_EN
        return rsp_count;
`else
        return 32'h0;
`endif
    endfunction

    // Drives one request and waits for its response; does no checking itself.
    task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op, input logic [3:0] tag,
                                  output logic [31:0] res, output logic [3:0] rtag,
                                  output logic err, output int lat, output bit ok);
        ok = 0; lat = 0; res = '0; rtag = '0; err = 1'b0;
        bus.i_rsp_ready = 1'b1;
        bus.i_a = a; bus.i_b = b; bus.i_op = op; bus.i_tag = tag;
        bus.i_req_valid = 1'b1;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (bus.o_rsp_valid) begin
                res = bus.o_res; rtag = bus.o_tag; err = bus.o_err;
                lat = k; ok = 1;
                rsp_count++;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.o_rsp_valid !== 1'b0 || bus.o_res !== 32'h0 || bus.o_tag !== 4'h0 ||
            bus.o_err !== 1'b0 || bus.o_ops !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b res=%h tag=%h err=%b ops=%0d, want all 0",
                     bus.o_rsp_valid, bus.o_res, bus.o_tag, bus.o_err, bus.o_ops);
        end
        n_tests++;
        if (bus.o_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b want 0", bus.o_req_ready);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b valid=%b want 1/0", bus.o_req_ready, bus.o_rsp_valid);
        end
    endtask

    task automatic run_table(input string name, input logic [31:0] a[], input logic [31:0] b[],
                             input logic [3:0] op[], input logic [3:0] tag[],
                             input logic [31:0] er[], input logic ee[]);
        logic [31:0] res; logic [3:0] rtag; logic err; int lat; bit ok;
        for (int i = 0; i < a.size(); i++) begin
            issue_and_wait(a[i], b[i], op[i], tag[i], res, rtag, err, lat, ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s[%0d]_timeout: no response, want one", name, i);
                continue;
            end
            n_tests++;
            if (res !== er[i] || rtag !== tag[i] || err !== ee[i]) begin
                n_fail++;
                $display("FAIL %s[%0d]: res=%h tag=%h err=%b want res=%h tag=%h err=%b",
                         name, i, res, rtag, err, er[i], tag[i], ee[i]);
            end
            n_tests++;
            if (lat != 2) begin
                n_fail++;
                $display("FAIL %s[%0d]_latency: got %0d negedges want 2", name, i, lat);
            end
        end
    endtask

    task automatic test_basic_ops();
        run_table("basic",
                  '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5},
                  '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3},
                  '{4'h0, 4'h8, 4'h1, 4'h4, 4'h6, 4'h7},
                  '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6},
                  '{32'd8, 32'd2, 32'd40, 32'd6, 32'd7, 32'd1},
                  '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_corners();
        run_table("corner",
                  '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000},
                  '{32'd1, 32'd1, 32'd36, 32'd36},
                  '{4'h2, 4'h3, 4'hD, 4'h5},
                  '{4'h7, 4'h8, 4'h9, 4'hB},
                  '{32'd1, 32'd0, 32'hF8000000, 32'h08000000},
                  '{1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_illegal();
        run_table("illegal",
                  '{32'd5, 32'd5},
                  '{32'd3, 32'd3},
                  '{4'hF, 4'h9},
                  '{4'hA, 4'h3},
                  '{32'd0, 32'd0},
                  '{1'b1, 1'b1});
    endtask

    task automatic test_back_to_back();
        bit ready_ok = 1;
        bus.i_rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (bus.o_rsp_valid !== (i >= 2 && i < 10)) begin
                n_fail++;
                $display("FAIL stream_valid[%0d]: got %b want %b", i, bus.o_rsp_valid, (i >= 2 && i < 10));
            end
            if (i >= 2 && i < 10) begin
                n_tests++;
                if (bus.o_res !== 32'(i - 2 + 100) || bus.o_tag !== 4'(i - 2)) begin
                    n_fail++;
                    $display("FAIL stream_rsp[%0d]: res=%0d tag=%0d want res=%0d tag=%0d",
                             i, bus.o_res, bus.o_tag, i - 2 + 100, i - 2);
                end
                if (bus.o_rsp_valid) rsp_count++;
            end
            if (i < 8 && bus.o_req_ready !== 1'b1) ready_ok = 0;
            if (i < 8) begin
                bus.i_a = 32'(i); bus.i_b = 32'd100; bus.i_op = 4'h0; bus.i_tag = 4'(i);
                bus.i_req_valid = 1'b1;
            end else begin
                bus.i_req_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_tests++;
        if (!ready_ok) begin
            n_fail++;
            $display("FAIL stream_ready: req_ready dropped during stream, want always 1");
        end
    endtask

    task automatic test_backpressure();
        bus.i_rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (bus.o_req_ready !== (i < 2)) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got %b want %b", i, bus.o_req_ready, (i < 2));
            end
            if (i >= 2) begin
                n_tests++;
                if (bus.o_rsp_valid !== 1'b1 || bus.o_res !== 32'd11 || bus.o_tag !== 4'h8) begin
                    n_fail++;
                    $display("FAIL bp_hold[%0d]: valid=%b res=%0d tag=%0d want 1/11/8",
                             i, bus.o_rsp_valid, bus.o_res, bus.o_tag);
                end
            end
            if (i < 5) begin
                bus.i_a = 32'(10 + (i < 2 ? i : 2)); bus.i_b = 32'd1; bus.i_op = 4'h0;
                bus.i_tag = 4'(8 + (i < 2 ? i : 2));
                bus.i_req_valid = 1'b1;
                @(negedge clk);
            end
        end
        bus.i_req_valid = 1'b0;
        bus.i_rsp_ready = 1'b1;
        rsp_count++;
        @(negedge clk);
        n_tests++;
        if (bus.o_rsp_valid !== 1'b1 || bus.o_res !== 32'd12 || bus.o_tag !== 4'h9) begin
            n_fail++;
            $display("FAIL bp_drain2: valid=%b res=%0d tag=%0d want 1/12/9",
                     bus.o_rsp_valid, bus.o_res, bus.o_tag);
        end
        if (bus.o_rsp_valid) rsp_count++;
        @(negedge clk);
        n_tests++;
        if (bus.o_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: valid=%b want 0 (extra response)", bus.o_rsp_valid);
        end
        n_tests++;
        if (bus.o_ops !== exp_ops()) begin
            n_fail++;
            $display("FAIL bp_ops: got %0d want %0d", bus.o_ops, exp_ops());
        end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        bus.i_rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.i_a = 32'(i + 1); bus.i_b = 32'd1; bus.i_op = 4'h0; bus.i_tag = 4'(i + 1);
            bus.i_req_valid = 1'b1;
            @(negedge clk);
        end
        bus.i_req_valid = 1'b0;
        n_tests++;
        if (bus.o_rsp_valid !== 1'b1 || bus.o_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre: valid=%b ready=%b want 1/0", bus.o_rsp_valid, bus.o_req_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        rsp_count = 0;
        n_tests++;
        if (bus.o_rsp_valid !== 1'b0 || bus.o_ops !== 32'h0 || bus.o_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: valid=%b ops=%0d ready=%b want 0/0/0",
                     bus.o_rsp_valid, bus.o_ops, bus.o_req_ready);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (bus.o_rsp_valid) seen++;
            @(negedge clk);
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_stale: got %0d stale responses want 0", seen);
        end
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            if (bus.o_rsp_valid) begin
                n_tests++;
                if (bus.o_res !== 32'(20 + seen + 5) || bus.o_tag !== 4'(12 + seen)) begin
                    n_fail++;
                    $display("FAIL rst_after[%0d]: res=%0d tag=%0d want %0d/%0d",
                             seen, bus.o_res, bus.o_tag, 20 + seen + 5, 12 + seen);
                end
                seen++;
                rsp_count++;
            end
            if (i < 3) begin
                bus.i_a = 32'(20 + i); bus.i_b = 32'd5; bus.i_op = 4'h0; bus.i_tag = 4'(12 + i);
                bus.i_req_valid = 1'b1;
            end else begin
                bus.i_req_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_tests++;
        if (seen != 3) begin
            n_fail++;
            $display("FAIL rst_after_count: got %0d responses want 3", seen);
        end
        n_tests++;
        if (bus.o_ops !== exp_ops()) begin
            n_fail++;
            $display("FAIL rst_ops: got %0d want %0d", bus.o_ops, exp_ops());
        end
    endtask

    initial begin
        bus.i_req_valid = 1'b0;
        bus.i_rsp_ready = 1'b1;
        bus.i_a = '0; bus.i_b = '0; bus.i_op = '0; bus.i_tag = '0;
        test_reset();
        test_basic_ops();
        test_corners();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Pipelined, handshaked execution wrapper around the integer ALU operation set. It accepts operand/opcode requests on a valid/ready channel, computes the result over two register stages, and returns tagged responses on a second valid/ready channel. It sits between the instruction issue logic and writeback, and is the consumer side of the request stream that the ALU bench drives.

## Interface
- `WIDTH`, 32, operand and result width (power of two, ≥ 8)
- `TAG_W`, 4, width of the opaque request tag carried to the response
- `i_clk` input 1: clock, rising edge
- `i_rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `i_req_valid` input 1: request present
- `o_req_ready` output 1: request accepted this cycle when high together with `i_req_valid`
- `i_a` input WIDTH: operand A
- `i_b` input WIDTH: operand B
- `i_op` input 4: opcode per `opcode.svh`
- `i_tag` input TAG_W: request tag
- `o_rsp_valid` output 1: response present
- `i_rsp_ready` input 1: response consumed when high together with `o_rsp_valid`
- `o_res` output WIDTH: result
- `o_tag` output TAG_W: tag of the request that produced `o_res`
- `o_err` output 1: opcode was not a defined encoding
- `o_ops` output 32: completed-response count (see Configuration)

## Operation
- Opcodes: ADD=4'h0, SLL=4'h1, SLT=4'h2, SLTU=4'h3, XOR=4'h4, SRL=4'h5, OR=4'h6, AND=4'h7, SUB=4'h8, SRA=4'hD. All other encodings are illegal: `o_res`=0, `o_err`=1.
- ADD/SUB wrap modulo 2^WIDTH; no carry/overflow output.
- Shifts use `i_b[$clog2(WIDTH)-1:0]` only; upper bits of B are ignored. SRA replicates `i_a[WIDTH-1]`.
- SLT: signed compare; SLTU: unsigned. The result is 1 or 0, zero-extended.
- Stage 1 (S1) registers A, B, op, tag, and valid. Stage 2 (S2) registers the computed result, tag, err, and valid. The ALU function is combinational between S1 and S2.
- Advance rules: `s2_adv = !s2_valid || i_rsp_ready`; `s1_adv = !s1_valid || s2_adv`; `o_req_ready = s1_adv`. The combinational path from `i_rsp_ready` to `o_req_ready` is allowed.
- No request is dropped or duplicated. Responses leave in acceptance order.

## Timing
- Reset (asynchronous, while `i_rst_n`=0): S1/S2 valid cleared, and `o_rsp_valid`, `o_res`, `o_tag`, `o_err`, `o_ops` all read 0. `o_req_ready` is forced to 0 while reset is asserted and reads 1 in the first cycle after release.
- Latency: a request accepted at edge N produces `o_rsp_valid`=1 after edge N+1, visible in cycle N+1 to N+2, provided the pipeline is not stalled.
- Throughput: one request per cycle while `i_rsp_ready`=1.
- Backpressure: while `o_rsp_valid` && !`i_rsp_ready`, the values `o_res`/`o_tag`/`o_err` are held stable. S1 may still fill if it is empty. Once both stages are full, `o_req_ready`=0.
- Simultaneous events: response consumption and new acceptance in the same cycle are both legal; with a full pipe and `i_rsp_ready`=1, `o_req_ready`=1.
- Reset mid-operation: all in-flight requests are discarded, and no response is emitted for them.

## Configuration
- `ALU_PIPE_STATS_EN` defined: `o_ops` increments by 1 on every response handshake (`o_rsp_valid` && `i_rsp_ready`), wraps from 32'hFFFFFFFF to 0, and is cleared by reset.
- Undefined: no counter register is built, and `o_ops` is tied to 32'h0.

## Test plan
- Single requests with A=5, B=3: ADD→8, SUB→2, SLL→40, XOR→6, OR→7, AND→1. Each returns with `o_err`=0 and the echoed tag.
- Signed/shift corners: SLT A=32'hFFFFFFFF, B=1 → 1. SLTU on the same operands → 0. SRA A=32'h80000000, B=36 → 32'hF8000000 (shift amount 4). SRL on the same operands → 32'h08000000.
- Illegal op 4'hF with tag 4'hA → `o_res`=0, `o_err`=1, `o_tag`=4'hA.
- Streaming: 8 back-to-back ADDs (tags 0–7) with `i_rsp_ready`=1 → 8 responses in tag order on consecutive cycles, and `o_req_ready` never drops.
- Backpressure: hold `i_rsp_ready`=0 for 5 cycles while driving requests → exactly 2 are accepted, `o_req_ready`=0 thereafter, and `o_res` stays stable. Releasing `i_rsp_ready` drains both in order with no loss.
- Reset mid-flight: assert `i_rsp_ready`=0, accept 2 requests, then pulse `i_rst_n` low asynchronously → `o_rsp_valid`=0 immediately, no stale response after release, and `o_ops`=0. With `ALU_PIPE_STATS_EN`, 3 completed responses then read `o_ops`=3.
